rca_chunked_adder: RTL and testbench
====================================

// Module: rca_chunked_adder
// PURPOSE
//   Parametrised multi-cycle ripple-carry adder/subtractor: adds two WIDTH-bit operands
//   CHUNK bits per clock, holding the inter-chunk carry in a register.
//   Successor to the fixed 4-bit combinational RCA. Adds width/chunk parameters,
//   subtract mode, signed-overflow flag and valid/ready handshakes on input and output.
//   Sits between operand producers and result consumers on the datapath.
// PARAMETERS
//   WIDTH  16  operand/result width in bits; must be a multiple of CHUNK
//   CHUNK   4  bits added per cycle; NCHUNK = WIDTH/CHUNK (CHUNK==WIDTH -> single-cycle add)
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operands/mode valid
//   in_ready   out  1      block can accept operands (high only in IDLE)
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   cin        in   1      carry-in (add mode only)
//   sub        in   1      0: a+b+cin; 1: a-b (a + ~b + 1, cin ignored)
//   out_valid  out  1      result valid (high only in DONE)
//   out_ready  in   1      consumer accepts result
//   sum        out  WIDTH  result
//   cout       out  1      carry-out of MSB (sub mode: 1 = no borrow)
//   overflow   out  1      two's-complement signed overflow
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, idx=0, carry=0, sum=0, cout=0, overflow=0,
//     out_valid=0; in_ready = (state==IDLE), so it reads 1 as soon as state is IDLE.
//   FSM IDLE -> BUSY -> DONE -> IDLE.
//   IDLE: in_ready=1. On in_valid at an edge: latch a_r=a, b_r = sub ? ~b : b,
//     carry = sub ? 1 : cin, sign bits a[WIDTH-1], b_eff[WIDTH-1]; clear sum to 0;
//     set idx=0; go BUSY.
//   BUSY: each edge, {carry, sum[idx*CHUNK +: CHUNK]} =
//     a_r[idx-chunk] + b_r[idx-chunk] + carry, computed at CHUNK+1 bits; idx++.
//     After chunk NCHUNK-1: cout = final carry;
//     overflow = (a_msb == b_eff_msb) && (sum[WIDTH-1] != a_msb); go DONE.
//     in_valid ignored; in_ready=0.
//   DONE: out_valid=1; sum/cout/overflow held stable until out_ready=1, then go IDLE.
//     A new in_valid in the same cycle is NOT accepted (in_ready=0); it is taken next cycle.
//   Latency: out_valid rises NCHUNK clocks after the accepting edge.
//   Minimum issue interval is NCHUNK+2 cycles: IDLE accept, NCHUNK x BUSY, DONE.
//   sum is only meaningful while out_valid=1; it is partially written during BUSY.
//   Results wrap modulo 2^WIDTH; no saturation.
//   Reset mid-BUSY or mid-DONE: operation discarded, all state to reset values;
//     no residual carry leaks into the next operation.
//   NCHUNK==1: BUSY lasts one cycle; idx width = max(1, clog2(NCHUNK)).
// TESTING (WIDTH=16, CHUNK=4 unless noted; out_ready=1 unless noted)
//   1 add 0x1234+0x0F0F, cin=0 -> sum=0x2143, cout=0, overflow=0, out_valid exactly 4 clk after accept.
//   2 add 0xFFFF+0x0001, cin=0 -> sum=0x0000, cout=1, overflow=0 (carry ripples through all 4 chunks).
//   3 add 0x7FFF+0x0001 -> sum=0x8000, overflow=1, cout=0; add 0x0000+0x0000, cin=1 -> sum=0x0001.
//   4 sub 0x0005-0x0007 (cin=1 applied, must be ignored) -> sum=0xFFFE, cout=0, overflow=0;
//     sub 0x8000-0x0001 -> sum=0x7FFF, cout=1, overflow=1.
//   5 out_ready=0 for 5 clk in DONE with in_valid held high -> out_valid, sum, cout, overflow
//     stable; in_ready=0. On release, next operand accepted one clk after the DONE->IDLE edge.
//   6 rst_n pulsed low during BUSY chunk 2 -> sum/cout/overflow/out_valid=0, in_ready=1;
//     next op 0x0001+0x0001 -> 0x0002. Repeat tests 1-2 with CHUNK=16 (latency 1) and CHUNK=1 (latency 16).

Source files
------------

// File: rtl/rca_chunked_adder.sv
`default_nettype none
// rca_chunked_adder: multi-cycle ripple-carry add/sub, CHUNK bits per clock, carry held in a register.
// Rev 1.0
module rca_chunked_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                         state;
  logic [IDXW-1:0]                idx;
  logic                           carry;
  logic [NCHUNK-1:0][CHUNK-1:0]   a_r;
  logic [NCHUNK-1:0][CHUNK-1:0]   b_r;
  logic [NCHUNK-1:0][CHUNK-1:0]   sum_r;
  logic                           a_msb;
  logic                           b_msb;
  logic [CHUNK:0]                 chunk_sum;
  logic                           last_chunk;

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign sum        = sum_r;
  assign last_chunk = (idx == IDXW'(NCHUNK - 1));
  assign chunk_sum  = {1'b0, a_r[idx]} + {1'b0, b_r[idx]} + {{CHUNK{1'b0}}, carry};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      carry    <= 1'b0;
      a_r      <= '0;
      b_r      <= '0;
      sum_r    <= '0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is a + ~b + 1: invert b here and seed the carry with 1.
            a_r   <= a;
            b_r   <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            a_msb <= a[WIDTH-1];
            b_msb <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
            sum_r <= '0;
            idx   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          sum_r[idx] <= chunk_sum[CHUNK-1:0];
          carry      <= chunk_sum[CHUNK];
          if (last_chunk) begin
            // The MSB of the result is produced by this final chunk.
            cout     <= chunk_sum[CHUNK];
            overflow <= (a_msb == b_msb) && (chunk_sum[CHUNK-1] != a_msb);
            idx      <= '0;
            state    <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rca_chunked_adder.sv
`default_nettype none
// tb_rca_chunked_adder: randomized + directed checks of three chunkings against an arithmetic model.
module tb_rca_chunked_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, cin, sub, out_ready;
  logic [15:0] a, b;

  logic        in_ready4, out_valid4, cout4, ovf4;
  logic [15:0] sum4;
  logic        in_ready16, out_valid16, cout16, ovf16;
  logic [15:0] sum16;
  logic        in_ready1, out_valid1, cout1, ovf1;
  logic [15:0] sum1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rca_chunked_adder #(.WIDTH(16), .CHUNK(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid4),
    .out_ready(out_ready), .sum(sum4), .cout(cout4), .overflow(ovf4));

  rca_chunked_adder #(.WIDTH(16), .CHUNK(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid16),
    .out_ready(out_ready), .sum(sum16), .cout(cout16), .overflow(ovf16));

  rca_chunked_adder #(.WIDTH(16), .CHUNK(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid1),
    .out_ready(out_ready), .sum(sum1), .cout(cout1), .overflow(ovf1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {overflow, cout, sum} from plain integer arithmetic.
  function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mcin, input logic msub);
    int          u, s;
    logic        c, o;
    logic [15:0] r;
    if (msub) begin
      u = int'(ma) - int'(mb);
      c = (ma >= mb);
      s = int'($signed(ma)) - int'($signed(mb));
    end else begin
      u = int'(ma) + int'(mb) + int'(mcin);
      c = (u >= 65536);
      s = int'($signed(ma)) + int'($signed(mb)) + int'(mcin);
    end
    r = u[15:0];
    o = (s > 32767) || (s < -32768);
    return {o, c, r};
  endfunction

  // Called just after the accepting edge; waits for each instance's result.
  task automatic collect(input logic [17:0] e);
    logic [2:0] seen = 3'b000;
    for (int k = 1; k <= 24 && seen != 3'b111; k++) begin
      @(posedge clk); #1;
      if (out_valid4 && !seen[0]) begin
        seen[0] = 1'b1;
        check("lat_c4", k, 4);
        check("res_c4", {ovf4, cout4, sum4}, e);
      end
      if (out_valid16 && !seen[1]) begin
        seen[1] = 1'b1;
        check("lat_c16", k, 1);
        check("res_c16", {ovf16, cout16, sum16}, e);
      end
      if (out_valid1 && !seen[2]) begin
        seen[2] = 1'b1;
        check("lat_c1", k, 16);
        check("res_c1", {ovf1, cout1, sum1}, e);
      end
    end
    if (seen != 3'b111) check("timeout_seen", seen, 3'b111);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 6 && !(in_ready4 && in_ready16 && in_ready1); i++) @(negedge clk);
    check("idle", {in_ready4, in_ready16, in_ready1}, 3'b111);
  endtask

  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tc, input logic ts);
    wait_idle();
    @(negedge clk);
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    collect(model(ta, tb, tc, ts));
  endtask

  initial begin
    logic [17:0] held;
    rst_n = 1'b0; in_valid = 1'b0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", {out_valid4, cout4, ovf4, sum4}, 19'd0);
    check("rst_rdy", {in_ready4, in_ready16, in_ready1}, 3'b111);
    @(negedge clk); rst_n = 1'b1;

    // Directed boundaries
    run_op(16'h1234, 16'h0F0F, 1'b0, 1'b0);
    check("model_t1", model(16'h1234, 16'h0F0F, 1'b0, 1'b0), {2'b00, 16'h2143});
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    run_op(16'h0000, 16'h0000, 1'b1, 1'b0);
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1);
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1);

    // Back-pressure in DONE with in_valid held high
    wait_idle();
    @(negedge clk);
    out_ready = 1'b0;
    a = 16'hABCD; b = 16'h1111; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    held = model(16'hABCD, 16'h1111, 1'b1, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 10 && !out_valid4; i++) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 14; i++) begin
      check("hold_c4", {out_valid4, in_ready4, ovf4, cout4, sum4}, {2'b10, held});
      @(posedge clk); #1;
    end
    check("hold_all", {out_valid16, out_valid1}, 2'b11);
    @(negedge clk);
    out_ready = 1'b1;
    a = 16'h0F00; b = 16'h00F0; cin = 1'b0; sub = 1'b1;
    @(posedge clk); #1;
    check("rel_idle", {in_ready4, out_valid4}, 2'b10);
    @(posedge clk); #1;
    check("rel_accept", in_ready4, 1'b0);
    in_valid = 1'b0;
    collect(model(16'h0F00, 16'h00F0, 1'b0, 1'b1));

    // Reset during BUSY chunk 2 with a live carry
    wait_idle();
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0; #1;
    check("midrst_out", {out_valid4, cout4, ovf4, sum4}, 19'd0);
    check("midrst_rdy", {in_ready4, in_ready16, in_ready1}, 3'b111);
    @(negedge clk); rst_n = 1'b1;
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0);

    // Randomized
    for (int n = 0; n < 40; n++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end
    run_op(16'h8000, 16'h8000, 1'b0, 1'b0);
    run_op(16'h0000, 16'h8000, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
